// File: rtl/cv32e40p_regfile_wb_arbiter.sv
// cv32e40p_regfile_wb_arbiter: register-file write-back arbiter (EX on port A, ordered LSU/FPU FIFO on port B).
// Optional forwarding compare logic is enabled by defining CV32E40P_REGFILE_WB_FWD_EN.
module cv32e40p_regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_we_i,
    input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    output logic                  ex_ready_o,
    input  logic                  lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_ready_o,
    input  logic                  fpu_valid_i,
    input  logic [ADDR_WIDTH-1:0] fpu_waddr_i,
    input  logic [DATA_WIDTH-1:0] fpu_wdata_i,
    output logic                  fpu_ready_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o,
    input  logic [ADDR_WIDTH-1:0] fwd_raddr_i,
    output logic                  fwd_hit_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OW-1:0] DEPTH = OW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(FIFO_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_d [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, idx;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  we_a_q, we_a_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, b_addr_q, b_addr_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, b_data_q, b_data_d;
    logic                  empty, lsu_xfer, fpu_xfer, lsu_push, fpu_push, waw, ex_acc;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready ignores the same-cycle pop, so a full FIFO can never see push and pop together.
    assign empty       = (occ_q == '0);
    assign lsu_ready_o = (occ_q < DEPTH);
    assign lsu_xfer    = lsu_valid_i && lsu_ready_o;
    assign fpu_ready_o = ((occ_q + OW'(lsu_xfer)) < DEPTH);
    assign fpu_xfer    = fpu_valid_i && fpu_ready_o;
    assign lsu_push    = lsu_xfer && (lsu_waddr_i != '0);
    assign fpu_push    = fpu_xfer && (fpu_waddr_i != '0);

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        if (lsu_push) begin
            addr_d[wr_ptr_d] = lsu_waddr_i;
            data_d[wr_ptr_d] = lsu_wdata_i;
            wr_ptr_d         = inc(wr_ptr_d);
        end
        if (fpu_push) begin
            addr_d[wr_ptr_d] = fpu_waddr_i;
            data_d[wr_ptr_d] = fpu_wdata_i;
            wr_ptr_d         = inc(wr_ptr_d);
        end
        rd_ptr_d = empty ? rd_ptr_q : inc(rd_ptr_q);
        occ_d    = occ_q + OW'(lsu_push) + OW'(fpu_push) - OW'(!empty);
        b_addr_d = empty ? b_addr_q : addr_q[rd_ptr_q];
        b_data_d = empty ? b_data_q : data_q[rd_ptr_q];
        waw      = (lsu_xfer && (lsu_waddr_i == ex_waddr_i)) || (fpu_xfer && (fpu_waddr_i == ex_waddr_i));
        idx      = rd_ptr_q;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if ((OW'(k) < occ_q) && (addr_q[idx] == ex_waddr_i)) waw = 1'b1;
            idx = inc(idx);
        end
        ex_ready_o = !(ex_we_i && waw);
        ex_acc     = ex_we_i && ex_ready_o;
        we_a_d     = ex_acc && (ex_waddr_i != '0);
        waddr_a_d  = ex_acc ? ex_waddr_i : waddr_a_q;
        wdata_a_d  = ex_acc ? ex_wdata_i : wdata_a_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '{default: '0};
            data_q    <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            we_a_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            we_a_q    <= we_a_d;
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            b_addr_q  <= b_addr_d;
            b_data_q  <= b_data_d;
        end
    end

    assign we_a_o    = we_a_q;
    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wdata_a_q;
    assign we_b_o    = !empty;
    assign waddr_b_o = b_addr_d;
    assign wdata_b_o = b_data_d;

`ifdef CV32E40P_REGFILE_WB_FWD_EN
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PW-1:0]         fidx;

    // Later matches override earlier ones, so the newest FIFO entry beats port A.
    always_comb begin
        fwd_hit  = we_a_q && (waddr_a_q == fwd_raddr_i);
        fwd_data = fwd_hit ? wdata_a_q : '0;
        fidx     = rd_ptr_q;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if ((OW'(k) < occ_q) && (addr_q[fidx] == fwd_raddr_i)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fidx];
            end
            fidx = inc(fidx);
        end
    end

    assign fwd_hit_o  = fwd_hit && (fwd_raddr_i != '0);
    assign fwd_data_o = fwd_hit_o ? fwd_data : '0;
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_raddr_i;
    assign fwd_hit_o  = 1'b0;
    assign fwd_data_o = '0;
`endif

endmodule
